zvc_line_compactor: RTL and testbench

//  Parametrised zero-value line compactor. Each input line holds LINE_SIZE lowered-IFM words and their mapping-table (MT) entries.

---
 rtl/zvc_line_compactor_pkg.sv | 16 +
 rtl/zvc_collapse_shifter.sv | 62 ++++++
 rtl/zvc_line_compactor.sv | 138 +++++++++++++
 tb/tb_zvc_line_compactor.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zvc_line_compactor_pkg.sv
// rtl/zvc_line_compactor_pkg.sv - keep-rule encodings and selection helper for the zero-value line compactor
package zvc_line_compactor_pkg;

    localparam int KEEP_MT   = 0;
    localparam int KEEP_WORD = 1;
    localparam int KEEP_ANY  = 2;

    function automatic logic keep_rule(input int mode, input logic word_nz, input logic mt_nz);
        case (mode)
            KEEP_WORD: return word_nz;
            KEEP_ANY:  return word_nz || mt_nz;
            default:   return mt_nz;
        endcase
    endfunction

endpackage

// File: rtl/zvc_collapse_shifter.sv
// rtl/zvc_collapse_shifter.sv - log-depth collapsing shifter packing kept elements toward slot 0
module zvc_collapse_shifter #(
    parameter int LINE_SIZE = 128,
    parameter int ELEM_W    = 36,
    parameter int CNT_WIDTH = 8
) (
    input  logic [LINE_SIZE*ELEM_W-1:0]    i_elem,
    input  logic [LINE_SIZE-1:0]           i_keep,
    input  logic [LINE_SIZE*CNT_WIDTH-1:0] i_zcnt,
    output logic [LINE_SIZE*ELEM_W-1:0]    o_line
);

    localparam int LOG2_LINE = $clog2(LINE_SIZE);

    logic [ELEM_W-1:0]    w_d  [LINE_SIZE];
    logic [ELEM_W-1:0]    w_nd [LINE_SIZE];
    logic [CNT_WIDTH-1:0] w_z  [LINE_SIZE];
    logic [CNT_WIDTH-1:0] w_nz [LINE_SIZE];
    logic [LINE_SIZE-1:0] w_v;
    logic [LINE_SIZE-1:0] w_nv;

    // LSB-first stages never collide: after stage k every kept element sits at
    // i - (zcnt mod 2^(k+1)), which stays strictly increasing across kept entries.
    always_comb begin
        w_v    = i_keep;
        w_nv   = '0;
        o_line = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            w_d[i]  = i_elem[i*ELEM_W +: ELEM_W];
            w_z[i]  = i_zcnt[i*CNT_WIDTH +: CNT_WIDTH];
            w_nd[i] = '0;
            w_nz[i] = '0;
        end
        for (int k = 0; k < LOG2_LINE; k++) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                int src;
                src     = i + (1 << k);
                w_nv[i] = 1'b0;
                w_nd[i] = '0;
                w_nz[i] = w_z[i];
                if (w_v[i] && !w_z[i][k]) begin
                    w_nv[i] = 1'b1;
                    w_nd[i] = w_d[i];
                end
                if (src < LINE_SIZE) begin
                    if (w_v[src] && w_z[src][k]) begin
                        w_nv[i] = 1'b1;
                        w_nd[i] = w_d[src];
                        w_nz[i] = w_z[src];
                    end
                end
            end
            w_d = w_nd;
            w_z = w_nz;
            w_v = w_nv;
        end
        for (int i = 0; i < LINE_SIZE; i++) begin
            o_line[i*ELEM_W +: ELEM_W] = w_v[i] ? w_d[i] : '0;
        end
    end

endmodule

// File: rtl/zvc_line_compactor.sv
// rtl/zvc_line_compactor.sv - two-stage valid/ready zero-value line compactor with keep mask and count
module zvc_line_compactor
    import zvc_line_compactor_pkg::*;
#(
    parameter int  WORD_WIDTH    = 8,
    parameter int  LINE_SIZE     = 128,
    parameter int  DIST_WIDTH    = 7,
    parameter int  MAX_LIFM_RSIZ = 4,
    parameter int  KEEP_MODE     = 0,
    localparam int MT_W          = DIST_WIDTH * MAX_LIFM_RSIZ,
    localparam int CNT_WIDTH     = $clog2(LINE_SIZE) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_bypass,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_line,
    input  logic [LINE_SIZE*MT_W-1:0]       mt_line,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
    output logic [LINE_SIZE*MT_W-1:0]       mt_comp,
    output logic [CNT_WIDTH-1:0]            out_count,
    output logic [LINE_SIZE-1:0]            out_mask
);

    localparam int ELEM_W = WORD_WIDTH + MT_W;

    logic [LINE_SIZE-1:0]           w_keep;
    logic [LINE_SIZE*CNT_WIDTH-1:0] w_zcnt;
    logic [CNT_WIDTH-1:0]           w_cnt;
    logic [CNT_WIDTH-1:0]           w_drop;
    logic [LINE_SIZE*ELEM_W-1:0]    w_elem;
    logic [LINE_SIZE*ELEM_W-1:0]    w_packed;
    logic [LINE_SIZE*WORD_WIDTH-1:0] w_lifm_packed;
    logic [LINE_SIZE*MT_W-1:0]      w_mt_packed;
    logic                           w_s1_en;
    logic                           w_s2_en;

    logic                           r_s1_valid;
    logic [LINE_SIZE*ELEM_W-1:0]    r_s1_elem;
    logic [LINE_SIZE-1:0]           r_s1_keep;
    logic [LINE_SIZE*CNT_WIDTH-1:0] r_s1_zcnt;
    logic [CNT_WIDTH-1:0]           r_s1_cnt;
    logic                           r_out_valid;
    logic [LINE_SIZE*WORD_WIDTH-1:0] r_lifm_comp;
    logic [LINE_SIZE*MT_W-1:0]      r_mt_comp;
    logic [CNT_WIDTH-1:0]           r_out_count;
    logic [LINE_SIZE-1:0]           r_out_mask;

    // Bypass forces every entry kept, which makes zcnt all-zero and cnt = LINE_SIZE.
    always_comb begin
        w_keep = '0;
        w_zcnt = '0;
        w_cnt  = '0;
        w_drop = '0;
        w_elem = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            w_keep[i] = in_bypass || keep_rule(KEEP_MODE,
                                               |lifm_line[i*WORD_WIDTH +: WORD_WIDTH],
                                               |mt_line[i*MT_W +: MT_W]);
            w_zcnt[i*CNT_WIDTH +: CNT_WIDTH] = w_drop;
            if (w_keep[i]) begin
                w_cnt = w_cnt + CNT_WIDTH'(1);
            end else begin
                w_drop = w_drop + CNT_WIDTH'(1);
            end
            w_elem[i*ELEM_W +: ELEM_W] = {mt_line[i*MT_W +: MT_W],
                                          lifm_line[i*WORD_WIDTH +: WORD_WIDTH]};
        end
    end

    zvc_collapse_shifter #(
        .LINE_SIZE (LINE_SIZE),
        .ELEM_W    (ELEM_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_shifter (
        .i_elem (r_s1_elem),
        .i_keep (r_s1_keep),
        .i_zcnt (r_s1_zcnt),
        .o_line (w_packed)
    );

    always_comb begin
        w_lifm_packed = '0;
        w_mt_packed   = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            w_lifm_packed[i*WORD_WIDTH +: WORD_WIDTH] = w_packed[i*ELEM_W +: WORD_WIDTH];
            w_mt_packed[i*MT_W +: MT_W]               = w_packed[i*ELEM_W + WORD_WIDTH +: MT_W];
        end
    end

    assign w_s2_en  = !r_out_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_elem   <= '0;
            r_s1_keep   <= '0;
            r_s1_zcnt   <= '0;
            r_s1_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_lifm_comp <= '0;
            r_mt_comp   <= '0;
            r_out_count <= '0;
            r_out_mask  <= '0;
        end else begin
            if (w_s2_en) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_lifm_comp <= w_lifm_packed;
                    r_mt_comp   <= w_mt_packed;
                    r_out_count <= r_s1_cnt;
                    r_out_mask  <= r_s1_keep;
                end
            end
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_elem <= w_elem;
                    r_s1_keep <= w_keep;
                    r_s1_zcnt <= w_zcnt;
                    r_s1_cnt  <= w_cnt;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign lifm_comp = r_lifm_comp;
    assign mt_comp   = r_mt_comp;
    assign out_count = r_out_count;
    assign out_mask  = r_out_mask;

endmodule

// File: tb/tb_zvc_line_compactor.sv
// tb/tb_zvc_line_compactor.sv - self-checking bench for zvc_line_compactor at LINE_SIZE=8, all keep modes
module tb_zvc_line_compactor;

    localparam int LS = 8;
    localparam int WW = 8;
    localparam int MW = 28;
    localparam int CW = 4;

    typedef struct packed {
        logic [LS*WW-1:0] w;
        logic [LS*MW-1:0] m;
        logic             b;
    } line_t;

    typedef struct packed {
        logic [LS*WW-1:0] lifm;
        logic [LS*MW-1:0] mt;
        logic [CW-1:0]    cnt;
        logic [LS-1:0]    mask;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_bypass;
    logic [LS*WW-1:0] lifm_line;
    logic [LS*MW-1:0] mt_line;
    logic             out_ready;
    logic             in_ready_c  [3];
    logic             out_valid_c [3];
    logic [LS*WW-1:0] lifm_c      [3];
    logic [LS*MW-1:0] mt_c        [3];
    logic [CW-1:0]    count_c     [3];
    logic [LS-1:0]    mask_c      [3];

    int    checks = 0;
    int    passed = 0;
    int    accepted = 0;
    int    n_out = 0;
    line_t q[$];
    logic  prev_stall = 1'b0;
    logic [LS*WW-1:0] prev_lifm;
    logic [LS*MW-1:0] prev_mt;
    logic [CW-1:0]    prev_cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        zvc_line_compactor #(
            .WORD_WIDTH(WW), .LINE_SIZE(LS), .DIST_WIDTH(7), .MAX_LIFM_RSIZ(4), .KEEP_MODE(g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_c[g]),
            .in_bypass (in_bypass),
            .lifm_line (lifm_line),
            .mt_line   (mt_line),
            .out_valid (out_valid_c[g]),
            .out_ready (out_ready),
            .lifm_comp (lifm_c[g]),
            .mt_comp   (mt_c[g]),
            .out_count (count_c[g]),
            .out_mask  (mask_c[g])
        );
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: walk the line, append every kept entry to the next free slot.
    function automatic exp_t model(input int mode, input line_t l);
        exp_t e;
        int   n;
        logic wnz, mnz, k;
        e = '0;
        n = 0;
        for (int j = 0; j < LS; j++) begin
            wnz = (l.w[j*WW +: WW] != 0);
            mnz = (l.m[j*MW +: MW] != 0);
            k   = l.b || (mode == 0 ? mnz : (mode == 1 ? wnz : (wnz || mnz)));
            if (k) begin
                e.mask[j]          = 1'b1;
                e.lifm[n*WW +: WW] = l.w[j*WW +: WW];
                e.mt[n*MW +: MW]   = l.m[j*MW +: MW];
                n++;
            end
        end
        e.cnt = CW'(n);
        return e;
    endfunction

    task automatic tick();
        line_t l;
        exp_t  e;
        @(negedge clk);
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 256'(out_valid_c[0]), 256'(1));
                chk("hold_lifm", 256'(lifm_c[0]), 256'(prev_lifm));
                chk("hold_mt", 256'(mt_c[0]), 256'(prev_mt));
                chk("hold_count", 256'(count_c[0]), 256'(prev_cnt));
            end
            if (out_valid_c[0] && out_ready) begin
                chk("out_has_ref", 256'(q.size() > 0), 256'(1));
                if (q.size() > 0) begin
                    l = q.pop_front();
                    for (int m = 0; m < 3; m++) begin
                        e = model(m, l);
                        chk($sformatf("m%0d_valid", m), 256'(out_valid_c[m]), 256'(1));
                        chk($sformatf("m%0d_lifm", m), 256'(lifm_c[m]), 256'(e.lifm));
                        chk($sformatf("m%0d_mt", m), 256'(mt_c[m]), 256'(e.mt));
                        chk($sformatf("m%0d_count", m), 256'(count_c[m]), 256'(e.cnt));
                        chk($sformatf("m%0d_mask", m), 256'(mask_c[m]), 256'(e.mask));
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready_c[0]) begin
                q.push_back('{lifm_line, mt_line, in_bypass});
                accepted++;
            end
            prev_stall = out_valid_c[0] && !out_ready;
            prev_lifm  = lifm_c[0];
            prev_mt    = mt_c[0];
            prev_cnt   = count_c[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_wait(input logic [LS*WW-1:0] w, input logic [LS*MW-1:0] m, input logic b);
        lifm_line = w;
        mt_line   = m;
        in_bypass = b;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", 256'(out_valid_c[0]), 256'(0));
        tick();
        chk("lat_cycle2_valid", 256'(out_valid_c[0]), 256'(1));
    endtask

    task automatic rand_line();
        int dens;
        dens = $urandom_range(0, 100);
        for (int j = 0; j < LS; j++) begin
            lifm_line[j*WW +: WW] = ($urandom_range(0, 99) < dens) ? WW'($urandom_range(1, 255)) : '0;
            mt_line[j*MW +: MW]   = ($urandom_range(0, 99) < dens) ? (MW'($urandom) | MW'(1)) : '0;
        end
        in_bypass = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        logic [LS*MW-1:0] mt_v;
        logic [LS*MW-1:0] mt_e;
        logic [LS*WW-1:0] w_v;
        line_t            bp_lines [5];
        logic             saw_stall;
        int               base;
        int               cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        lifm_line = '0;
        mt_line   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 256'(out_valid_c[0]), 256'(0));
        chk("rst_lifm", 256'(lifm_c[0]), 256'(0));
        chk("rst_mt", 256'(mt_c[0]), 256'(0));
        chk("rst_count", 256'(count_c[0]), 256'(0));
        chk("rst_mask", 256'(mask_c[0]), 256'(0));
        chk("rst_in_ready", 256'(in_ready_c[0]), 256'(1));

        // Sparse line: MT nonzero at entries 1, 4, 6.
        mt_v = '0;
        mt_v[1*MW +: MW] = 28'h1;
        mt_v[4*MW +: MW] = 28'h4;
        mt_v[6*MW +: MW] = 28'h6;
        mt_e = '0;
        mt_e[0*MW +: MW] = 28'h1;
        mt_e[1*MW +: MW] = 28'h4;
        mt_e[2*MW +: MW] = 28'h6;
        send_and_wait(64'h0066_0044_0000_1100, mt_v, 1'b0);
        chk("sparse_lifm", 256'(lifm_c[0]), 256'(64'h0000_0000_0066_4411));
        chk("sparse_mt", 256'(mt_c[0]), 256'(mt_e));
        chk("sparse_count", 256'(count_c[0]), 256'(3));
        chk("sparse_mask", 256'(mask_c[0]), 256'(8'b0101_0010));

        send_and_wait('0, '0, 1'b0);
        chk("zero_count", 256'(count_c[0]), 256'(0));
        chk("zero_lifm", 256'(lifm_c[0]), 256'(0));
        chk("zero_mask", 256'(mask_c[0]), 256'(0));

        for (int j = 0; j < LS; j++) mt_v[j*MW +: MW] = MW'(j + 1);
        send_and_wait(64'h0807_0605_0403_0201, mt_v, 1'b0);
        chk("full_lifm", 256'(lifm_c[0]), 256'(64'h0807_0605_0403_0201));
        chk("full_mt", 256'(mt_c[0]), 256'(mt_v));
        chk("full_count", 256'(count_c[0]), 256'(8));

        mt_v = '0;
        mt_v[1*MW +: MW] = 28'h1;
        send_and_wait(64'h0000_0000_0000_1100, mt_v, 1'b1);
        chk("bypass_lifm", 256'(lifm_c[0]), 256'(64'h0000_0000_0000_1100));
        chk("bypass_count", 256'(count_c[0]), 256'(8));
        chk("bypass_mask", 256'(mask_c[0]), 256'(8'hff));

        // Entry 2 carries a zero word with a nonzero MT entry.
        mt_v = '0;
        mt_v[0*MW +: MW] = 28'ha;
        mt_v[2*MW +: MW] = 28'h2;
        send_and_wait(64'h0000_0000_0000_00a0, mt_v, 1'b0);
        chk("mode1_count", 256'(count_c[1]), 256'(1));
        chk("mode1_mask", 256'(mask_c[1]), 256'(8'b0000_0001));
        chk("mode2_count", 256'(count_c[2]), 256'(2));
        chk("mode2_mask", 256'(mask_c[2]), 256'(8'b0000_0101));
        chk("mode2_mt", 256'(mt_c[2]), 256'({28'h2, 28'ha}));
        tick();

        // Backpressure: five back-to-back lines, out_ready low for cycles 3..6.
        for (int k = 0; k < 5; k++) begin
            rand_line();
            bp_lines[k] = '{lifm_line, mt_line, in_bypass};
        end
        base      = accepted;
        saw_stall = 1'b0;
        n_out     = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (accepted - base) < 5;
            if (in_valid) {lifm_line, mt_line, in_bypass} = bp_lines[accepted - base];
            out_ready = !(c >= 3 && c <= 6);
            if (in_valid && !in_ready_c[0]) saw_stall = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_in_ready_low_seen", 256'(saw_stall), 256'(1));
        chk("bp_all_out", 256'(n_out), 256'(5));
        chk("bp_queue_empty", 256'(q.size()), 256'(0));

        // Reset with two lines in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_line();
        tick();
        rand_line();
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", 256'(out_valid_c[0]), 256'(0));
        chk("midrst_in_ready", 256'(in_ready_c[0]), 256'(1));
        out_ready = 1'b1;
        n_out     = 0;
        repeat (3) tick();
        chk("midrst_no_emit", 256'(n_out), 256'(0));
        send_and_wait(64'h0102_0304_0506_0708, '0, 1'b1);
        chk("post_rst_count", 256'(count_c[0]), 256'(8));
        tick();

        // Random traffic with random output stalls.
        base = accepted;
        cyc  = 0;
        while ((accepted - base) < 10000 && cyc < 80000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_line();
            tick();
            cyc++;
        end
        chk("rand_accepted", 256'(accepted - base), 256'(10000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", 256'(q.size()), 256'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
